// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register-0 index and data/address types for reg_file.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with x0 masking and enable gating.
// REGFILE_BYPASS_EN adds same-cycle write-through forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] rs,
    input  logic              enable,
    input  logic              wr_hit,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] out
);
    logic zero;
    assign zero = !enable || rs == ADDR_W'(ZERO_REG);
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        out = zero ? '0 : (wr_hit && rs == rd) ? din : regs[rs];
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_hit, rd, din};
    always_comb begin
        out = zero ? '0 : regs[rs];
    end
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 32 register file, two combinational reads, one synchronous write, x0 = 0.
// Define REGFILE_BYPASS_EN for write-through forwarding to the read ports.
module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] din,
    input  logic              enable,
    input  logic              rw,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic wr_en;
    logic wr_hit;
    assign wr_en = enable && rw && rd != ADDR_W'(ZERO_REG);
    assign wr_hit = wr_en && !reset;
    always_ff @(posedge clk) begin
        if (reset) regs <= '{default: '0};
        else if (wr_en) regs[rd] <= din;
    end
    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
        .regs(regs), .rs(rs1), .enable(enable), .wr_hit(wr_hit), .rd(rd), .din(din), .out(out1)
    );
    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
        .regs(regs), .rs(rs2), .enable(enable), .wr_hit(wr_hit), .rd(rd), .din(din), .out(out2)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file; stimulus queues expected reads, monitor checks at negedge.
module tb_reg_file;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, enable, rw;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] din, out1, out2;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;
    exp_t q[$];

    reg_file dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd), .din(din),
        .enable(enable), .rw(rw), .out1(out1), .out2(out2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (out1 !== e.e1 || out2 !== e.e2) begin
                errors++;
                $display("FAIL %s: out1=%h out2=%h expected out1=%h out2=%h", e.name, out1, out2, e.e1, e.e2);
            end
        end
    end

    task automatic drive(input logic r, input logic en, input logic w, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] d, input logic [31:0] v);
        @(posedge clk);
        #1;
        reset = r; enable = en; rw = w; rs1 = a1; rs2 = a2; rd = d; din = v;
    endtask

    task automatic expect_out(input string n, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.name = n; e.e1 = e1; e.e2 = e2;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; rw = 1'b0; rs1 = 5'd17; rs2 = 5'd5; rd = 5'd0; din = '0;
        drive(1, 1, 0, 17, 5, 0, 0);
        drive(0, 1, 0, 17, 5, 0, 0);
        expect_out("reset_read", 32'd0, 32'd0);

        drive(0, 1, 1, 17, 0, 17, 32'd37);
        expect_out("write17_same_cycle", BYP ? 32'd37 : 32'd0, 32'd0);
        drive(0, 1, 0, 17, 0, 17, 32'd99);
        expect_out("read17", 32'd37, 32'd0);
        drive(0, 1, 0, 17, 17, 17, 32'd123);
        expect_out("read17_hold", 32'd37, 32'd37);

        for (int k = 1; k <= 29; k += 2) begin
            drive(0, 1, 1, 0, 0, 5'(k), 32'd1 << k);
            drive(0, 1, 1, 0, 0, 5'(k + 1), 32'd1073741824 >> k);
            drive(0, 1, 0, 5'(k), 5'(k + 1), 0, 0);
            expect_out($sformatf("sweep_k%0d", k), 32'd1 << k, 32'd1073741824 >> k);
        end
        drive(0, 1, 0, 1, 2, 0, 0);
        expect_out("sweep_early", 32'd2, 32'd536870912);

        drive(0, 1, 0, 5, 6, 5, 32'hDEADBEEF);
        expect_out("gate_rw0", 32'd32, 32'd33554432);
        drive(0, 0, 1, 5, 6, 5, 32'hDEADBEEF);
        expect_out("gate_en0_out", 32'd0, 32'd0);
        drive(0, 1, 0, 5, 5, 0, 0);
        expect_out("gate_kept", 32'd32, 32'd32);

        drive(0, 1, 1, 0, 0, 0, 32'hFFFFFFFF);
        expect_out("x0_write_cycle", 32'd0, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0);
        expect_out("x0_read", 32'd0, 32'd0);

        drive(1, 1, 1, 9, 0, 9, 32'd7);
        expect_out("reset_write_cycle", 32'd512, 32'd0);
        drive(0, 1, 0, 9, 9, 0, 0);
        expect_out("reset_priority", 32'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 0, 5'(i), 5'(31 - i), 0, 0);
            expect_out($sformatf("reset_clear_%0d", i), 32'd0, 32'd0);
        end

        drive(0, 1, 1, 3, 3, 3, 32'h55);
        expect_out("bypass_cycle", BYP ? 32'h55 : 32'd0, BYP ? 32'h55 : 32'd0);
        drive(0, 1, 0, 3, 4, 0, 0);
        expect_out("after_write3", 32'h55, 32'd0);
        drive(0, 0, 1, 3, 3, 3, 32'h77);
        expect_out("bypass_en0", 32'd0, 32'd0);
        drive(0, 1, 0, 3, 0, 5'bx, 32'bx);
        expect_out("x_rd_rw0", 32'h55, 32'd0);
        drive(0, 1, 0, 3, 3, 0, 0);
        expect_out("x_rd_no_corrupt", 32'h55, 32'h55);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
